display_sched: RTL
==================

# display_sched

Refresh scheduler for the CHIP-8 UART display path. Sits between the CPU's draw/clear events and the `Display` serializer. Decides when a frame is shipped:
- on a fixed refresh tick, only when the screen is dirty;
- snapshots the framebuffer, fires the one-cycle `set` kick, then holds off until the serializer has finished the frame.

It also counts frames sent and refresh ticks missed while busy.

## Interface
- `TICK_DIV`, default 200000: clk cycles per refresh tick (≥2).
- `HOLDOFF`, default 250000: cycles held in HOLD after the kick, covering the full UART frame time (≥1).
- `clk`  in  1: system clock, rising edge.
- `rst_n`  in  1: reset; one clock; reset is asynchronous and active-low.
- `draw_req`  in  1: one-cycle pulse, CPU executed DXYN (screen modified).
- `clr_req`  in  1: one-cycle pulse, CPU executed 00E0.
- `snap`  out  1: one-cycle strobe, latch `screen` into the display shadow copy.
- `set`  out  1: one-cycle kick to `Display.set`.
- `busy`  out  1: high in SNAP, KICK and HOLD.
- `dirty`  out  1: a screen change is pending transmission.
- `frames_sent`  out  16: frames kicked, wraps at 65535→0.
- `missed_ticks`  out  8: refresh ticks that arrived while busy, saturates at 255.

## Operation
- States: IDLE → SNAP → KICK → HOLD → IDLE.
- Tick divider: counter `0..TICK_DIV-1`; `tick` is high in the cycle the counter equals `TICK_DIV-1`; the counter then wraps to 0. The divider free-runs in every state.
- IDLE:
  - tick && dirty → SNAP.
  - tick && !dirty → stay in IDLE, no count.
- SNAP (1 cycle): `snap=1`. Clear `dirty`, unless `draw_req|clr_req` is high in this same cycle; then `dirty` stays 1 (that change lands after the snapshot).
- KICK (1 cycle): `set=1`; `frames_sent++`.
- HOLD: hold counter loads `HOLDOFF-1` on entry and decrements each cycle. Exit to IDLE the cycle after it reads 0. HOLD lasts exactly `HOLDOFF` cycles.
- `dirty`:
  - set by `draw_req` or `clr_req` in any state, except as noted for SNAP;
  - reset value 1, so the first tick ships the initial screen.
- tick while state≠IDLE: `missed_ticks` increments (saturating); the tick is dropped, not queued.
- `draw_req` and `clr_req` in the same cycle are treated as one event.

## Timing
- Reset values: `snap=0`, `set=0`, `busy=0`, `dirty=1`, `frames_sent=0`, `missed_ticks=0`, state IDLE, both counters 0.
- Reset takes effect immediately, mid-frame included: outputs drop asynchronously. The interrupted frame is abandoned, not counted, and not re-sent unless dirty.
- All outputs are registered.
- Tick in cycle T with dirty:
  - `snap` at T+1;
  - `set` and the `frames_sent` update at T+2;
  - HOLD spans T+3..T+2+HOLDOFF;
  - IDLE at T+3+HOLDOFF.
- `busy` is high from T+1 through T+2+HOLDOFF.
- A tick coinciding with the last HOLD cycle counts as missed. A tick in the first IDLE cycle is served.
- Minimum frame spacing is one tick period. If `HOLDOFF+2 ≥ TICK_DIV`, every other tick is missed.

## Configuration
- `DISP_SCHED_FORCE_REFRESH_EN`:
  - Defined: IDLE goes to SNAP on every tick regardless of `dirty`. Frames are sent periodically even with no screen change, so a late-attached UART terminal resyncs. `dirty` still tracks and clears as specified.
  - Undefined: frames are sent only when `dirty`.

## Structure
- Package `disp_sched_pkg`:
  - state enum `disp_sched_state_t` (IDLE, SNAP, KICK, HOLD);
  - default constants `DISP_TICK_DIV_DEF`, `DISP_HOLDOFF_DEF`;
  - counter widths `FRAMES_W=16`, `MISSED_W=8`.
- Sub-module `refresh_tick_gen`: parameterised by `TICK_DIV`, outputs one-cycle `tick`. Counter width is `$clog2(TICK_DIV)`.
- Top holds the FSM, hold counter, dirty flag and stat counters.

## Test plan
Bench parameters: `TICK_DIV=100`, `HOLDOFF=40`, macro undefined unless stated.
- Release reset, no requests → first tick at cycle 99. `snap` at 100, `set` at 101, `frames_sent=1`. Next tick (199) sends nothing; `dirty=0`.
- `draw_req` at cycle 150 → `dirty=1`. Tick 199 → `snap` at 200, `set` at 201, `frames_sent=2`, `busy` low again at cycle 242.
- `draw_req` in the SNAP cycle (200) → `dirty` remains 1 afterwards. The next tick (299) sends frame 3.
- Rebuild with `HOLDOFF=150`, continuous `draw_req` → every second tick sets `missed_ticks+1`. Force 300 missed ticks → reads 255.
- Assert `rst_n=0` mid-HOLD → `busy`, `set`, `snap` low immediately. `frames_sent=0`, `dirty=1`, and the first tick after release sends a frame.
- Rebuild with `DISP_SCHED_FORCE_REFRESH_EN`, no requests → `set` on every tick; `frames_sent` reaches 5 after 5 ticks.

Source files
------------

// File: rtl/disp_sched_pkg.sv
// Shared types and constants for the display refresh scheduler.
package disp_sched_pkg;
  typedef enum logic [1:0] {IDLE, SNAP, KICK, HOLD} disp_sched_state_t;

  localparam int DISP_TICK_DIV_DEF = 200000;
  localparam int DISP_HOLDOFF_DEF  = 250000;
  localparam int FRAMES_W          = 16;
  localparam int MISSED_W          = 8;
endpackage

// File: rtl/refresh_tick_gen.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks.
module refresh_tick_gen
  import disp_sched_pkg::*;
#(
  parameter int TICK_DIV = DISP_TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);
endmodule

// File: rtl/display_sched.sv
// Refresh scheduler for the UART display path: snapshot, kick, hold off until the frame is out.
// Optional build macro DISP_SCHED_FORCE_REFRESH_EN ships a frame on every tick regardless of dirty.
module display_sched
  import disp_sched_pkg::*;
#(
  parameter int TICK_DIV = DISP_TICK_DIV_DEF,
  parameter int HOLDOFF  = DISP_HOLDOFF_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                draw_req,
  input  logic                clr_req,
  output logic                snap,
  output logic                set,
  output logic                busy,
  output logic                dirty,
  output logic [FRAMES_W-1:0] frames_sent,
  output logic [MISSED_W-1:0] missed_ticks
);
  localparam int HW = $clog2(HOLDOFF + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF - 1);

  disp_sched_state_t state, next;
  logic              tick, ev, ship, hold_done;
  logic [HW-1:0]     hold_cnt;

  refresh_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign ev        = draw_req | clr_req;
  assign hold_done = (hold_cnt == '0);
`ifdef DISP_SCHED_FORCE_REFRESH_EN
  assign ship = tick;
`else
  assign ship = tick & dirty;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (ship) next = SNAP;
      SNAP:    next = KICK;
      KICK:    next = HOLD;
      HOLD:    if (hold_done) next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Strobes are decoded from next state so every output comes straight off a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap         <= 1'b0;
      set          <= 1'b0;
      busy         <= 1'b0;
      dirty        <= 1'b1;
      frames_sent  <= '0;
      missed_ticks <= '0;
      hold_cnt     <= '0;
    end else begin
      snap <= (next == SNAP);
      set  <= (next == KICK);
      busy <= (next != IDLE);
      // A change arriving during the snapshot cycle lands after it, so it stays pending.
      if (state == SNAP) dirty <= ev;
      else if (ev)       dirty <= 1'b1;
      if (next == KICK) frames_sent <= frames_sent + FRAMES_W'(1);
      if (tick && state != IDLE && missed_ticks != '1)
        missed_ticks <= missed_ticks + MISSED_W'(1);
      if (state == KICK)                  hold_cnt <= HOLD_LOAD;
      else if (state == HOLD && !hold_done) hold_cnt <= hold_cnt - HW'(1);
    end
  end
endmodule
